debounce_bank: RTL

- Multi-channel, parametrised debouncer for mechanical inputs such as keyboard matrix lines, DIP switches and front-panel buttons.
- Each channel has its own input synchroniser, stability counter, debounced level and one-cycle rise/fall strobes.
- An aggregate change strobe lets a scanner or interrupt block react without polling every channel.
- Sits between the raw pins and the keyboard/front-panel logic.

---
 rtl/debounce_bank.sv | 124 ++++++++++++
 1 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: a bank of independent debouncers for mechanical inputs.
// Each channel synchronises its raw pin, then requires DEBOUNCE_LIMIT
// consecutive synchronised samples that disagree with the current debounced
// level before that level flips. A flip produces a one-cycle rise or fall
// strobe, and the bank raises a single aggregate change strobe in the same
// cycle so a scanner can react without polling every channel.

module debounce_channel #(
    parameter int   DEBOUNCE_LIMIT = 10,
    parameter int   SYNC_STAGES    = 2,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic flip
);
    // Counter is wide enough to hold DEBOUNCE_LIMIT, but only ever reaches
    // DEBOUNCE_LIMIT-1: the sample that would take it further flips instead.
    localparam int               CNT_W    = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       count_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   synced;
    logic                   differ;
    logic                   at_last;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign differ  = synced ^ level_q;
    assign at_last = (count_q == CNT_LAST);
    assign flip    = differ & at_last;

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

    // Input synchroniser; reset preloads every stage with the reset level so
    // the first post-reset samples never disagree with the debounced level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Stability counter: counts consecutive disagreeing samples, any agreeing
    // sample (a glitch back to the current level) restarts it from zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else if (!differ || at_last) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Debounced level plus registered strobes, which are high exactly in the
    // first cycle the new level is visible.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= flip & synced;
            fall_q <= flip & ~synced;
            if (flip) begin
                level_q <= synced;
            end
        end
    end
endmodule

module debounce_bank #(
    parameter int                  CHANNELS       = 8,
    parameter int                  DEBOUNCE_LIMIT = 10,
    parameter int                  SYNC_STAGES    = 2,
    parameter logic [CHANNELS-1:0] RESET_STATE    = {CHANNELS{1'b0}}
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CHANNELS-1:0] i_in,
    output logic [CHANNELS-1:0] o_state,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic                o_changed
);
    logic [CHANNELS-1:0] flip_vec;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .SYNC_STAGES    (SYNC_STAGES),
            .RESET_LEVEL    (RESET_STATE[g])
        ) u_chan (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .din   (i_in[g]),
            .level (o_state[g]),
            .rise  (o_rise[g]),
            .fall  (o_fall[g]),
            .flip  (flip_vec[g])
        );
    end

    // Aggregate strobe, registered from the same flip decisions so it lines
    // up with the per-channel rise/fall strobes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_changed <= 1'b0;
        end else begin
            o_changed <= |flip_vec;
        end
    end
endmodule
